// File: rtl/cic_pkg.sv
// cic_pkg: shared types and constants for the PDM CIC timing controller.
//   cic_state_e - sweep FSM states
//   DEF_*       - power-on timing configuration
//   cfg_legal() - legality test applied to every configuration load
package cic_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_COMPUTE = 2'd2,
        S_HOLD    = 2'd3
    } cic_state_e;

    localparam int DEF_DIV         = 49;
    localparam int DEF_READ_TIME   = 28;
    localparam int DEF_SAMPLE_RATE = 186;

    // A period shorter than 4 clocks leaves no room for two pdm_clk phases,
    // and a read point beyond the period would never be reached.
    function automatic logic cfg_legal(input int unsigned div, input int unsigned read_time);
        return (div >= 32'd3) && (read_time <= div);
    endfunction

endpackage

// File: rtl/cic_cfg_shadow.sv
// cic_cfg_shadow: pending/active configuration registers.
//   clk_i, resetn_i          - clock, synchronous active-high reset
//   cfg_*_i, cfg_load_i      - configuration captured on cfg_load_i
//   apply_i                  - decimation boundary; pending config goes active
//   div_o .. dual_edge_o     - active configuration
//   load_ok_o                - combinational: this cycle's load is accepted
//   cfg_ack_o, cfg_reject_o  - registered one-cycle status pulses
module cic_cfg_shadow
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int DIV_WIDTH       = 8,
    parameter int DEF_DIV         = 49,
    parameter int DEF_READ_TIME   = 28,
    parameter int DEF_SAMPLE_RATE = 186
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic [DIV_WIDTH-1:0]  cfg_read_time_i,
    input  logic [DATA_WIDTH-1:0] cfg_sample_rate_i,
    input  logic                  cfg_dual_edge_i,
    input  logic                  cfg_load_i,
    input  logic                  apply_i,
    output logic [DIV_WIDTH-1:0]  div_o,
    output logic [DIV_WIDTH-1:0]  read_time_o,
    output logic [DATA_WIDTH-1:0] sample_rate_o,
    output logic                  dual_edge_o,
    output logic                  load_ok_o,
    output logic                  cfg_ack_o,
    output logic                  cfg_reject_o
);

    logic [DIV_WIDTH-1:0]  pend_div_q, pend_rt_q, act_div_q, act_rt_q;
    logic [DATA_WIDTH-1:0] pend_sr_q, act_sr_q;
    logic                  pend_dual_q, act_dual_q, pend_vld_q;
    logic                  ack_q, rej_q;
    logic                  legal;
    logic                  apply_now;

    assign legal     = cfg_legal(32'(cfg_div_i), 32'(cfg_read_time_i));
    assign load_ok_o = cfg_load_i && legal;
    assign apply_now = apply_i && pend_vld_q;

    always_ff @(posedge clk_i) begin
        if (resetn_i) begin
            act_div_q   <= DIV_WIDTH'(DEF_DIV);
            act_rt_q    <= DIV_WIDTH'(DEF_READ_TIME);
            act_sr_q    <= DATA_WIDTH'(DEF_SAMPLE_RATE);
            act_dual_q  <= 1'b0;
            pend_div_q  <= DIV_WIDTH'(DEF_DIV);
            pend_rt_q   <= DIV_WIDTH'(DEF_READ_TIME);
            pend_sr_q   <= DATA_WIDTH'(DEF_SAMPLE_RATE);
            pend_dual_q <= 1'b0;
            pend_vld_q  <= 1'b0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            ack_q <= apply_now;
            rej_q <= cfg_load_i && !legal;
            if (apply_now) begin
                act_div_q  <= pend_div_q;
                act_rt_q   <= pend_rt_q;
                act_sr_q   <= pend_sr_q;
                act_dual_q <= pend_dual_q;
            end
            // A load on the boundary cycle refills the pending slot after
            // the old contents moved to active, so it waits a full ratio.
            if (load_ok_o) begin
                pend_div_q  <= cfg_div_i;
                pend_rt_q   <= cfg_read_time_i;
                pend_sr_q   <= cfg_sample_rate_i;
                pend_dual_q <= cfg_dual_edge_i;
                pend_vld_q  <= 1'b1;
            end else if (apply_i) begin
                pend_vld_q  <= 1'b0;
            end
        end
    end

    assign div_o         = act_div_q;
    assign read_time_o   = act_rt_q;
    assign sample_rate_o = act_sr_q;
    assign dual_edge_o   = act_dual_q;
    assign cfg_ack_o     = ack_q;
    assign cfg_reject_o  = rej_q;

endmodule

// File: rtl/cic_timing_ctrl.sv
// cic_timing_ctrl: PDM clock, read strobe, channel sweep and decimation
// strobe generator for the CIC decimator.
//   clk, resetn                  - clock, synchronous active-high reset
//   cfg_* / cfg_load             - shadowed runtime configuration
//   cfg_ack, cfg_reject          - configuration status pulses
//   pdm_clk                      - microphone clock
//   read_enable, edge_sel        - sample strobe and which read point
//   integrator_enable, channel   - per-channel integrator sweep
//   comb_enable                  - decimation strobe
//   overrun                      - sticky dropped-read-point flag
module cic_timing_ctrl #(
    parameter int CHANNELS        = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int DIV_WIDTH       = 8,
    parameter int DEF_DIV         = cic_pkg::DEF_DIV,
    parameter int DEF_READ_TIME   = cic_pkg::DEF_READ_TIME,
    parameter int DEF_SAMPLE_RATE = cic_pkg::DEF_SAMPLE_RATE,
    parameter int CHANNELS_WIDTH  = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [DIV_WIDTH-1:0]      cfg_div,
    input  logic [DIV_WIDTH-1:0]      cfg_read_time,
    input  logic [DATA_WIDTH-1:0]     cfg_sample_rate,
    input  logic                      cfg_dual_edge,
    input  logic                      cfg_load,
    output logic                      cfg_ack,
    output logic                      cfg_reject,
    output logic                      pdm_clk,
    output logic                      read_enable,
    output logic                      edge_sel,
    output logic                      integrator_enable,
    output logic [CHANNELS_WIDTH-1:0] channel,
    output logic                      comb_enable,
    output logic                      overrun
);
    import cic_pkg::*;

    logic [DIV_WIDTH-1:0]  div, read_time;
    logic [DATA_WIDTH-1:0] sample_rate;
    logic                  dual_edge, load_ok, comb_en;

    cic_cfg_shadow #(
        .DATA_WIDTH(DATA_WIDTH), .DIV_WIDTH(DIV_WIDTH), .DEF_DIV(DEF_DIV),
        .DEF_READ_TIME(DEF_READ_TIME), .DEF_SAMPLE_RATE(DEF_SAMPLE_RATE)
    ) u_cfg (
        .clk_i(clk), .resetn_i(resetn),
        .cfg_div_i(cfg_div), .cfg_read_time_i(cfg_read_time),
        .cfg_sample_rate_i(cfg_sample_rate), .cfg_dual_edge_i(cfg_dual_edge),
        .cfg_load_i(cfg_load), .apply_i(comb_en),
        .div_o(div), .read_time_o(read_time), .sample_rate_o(sample_rate),
        .dual_edge_o(dual_edge), .load_ok_o(load_ok),
        .cfg_ack_o(cfg_ack), .cfg_reject_o(cfg_reject)
    );

    // Phase and decimation counters
    logic [DIV_WIDTH-1:0]  sys_count_q, sys_count_d;
    logic [DATA_WIDTH-1:0] comb_count_q, comb_count_d;
    logic [DIV_WIDTH:0]    period, half, p1_sum, p1_pt;
    logic                  wrap, hit_p0, hit_p1, read_pt;

    assign wrap    = (sys_count_q == div);
    assign comb_en = wrap && (comb_count_q == sample_rate);

    assign sys_count_d  = wrap ? '0 : sys_count_q + DIV_WIDTH'(1);
    assign comb_count_d = !wrap ? comb_count_q
                        : (comb_en ? '0 : comb_count_q + DATA_WIDTH'(1));

    // Second read point sits half a period after the first, wrapped into
    // the period; one extra bit keeps read_time + half from overflowing.
    assign period  = {1'b0, div} + (DIV_WIDTH+1)'(1);
    assign half    = period >> 1;
    assign p1_sum  = {1'b0, read_time} + half;
    assign p1_pt   = (p1_sum >= period) ? p1_sum - period : p1_sum;
    assign hit_p0  = (sys_count_q == read_time);
    assign hit_p1  = dual_edge && ({1'b0, sys_count_q} == p1_pt);
    assign read_pt = hit_p0 || hit_p1;

    // Sweep FSM
    cic_state_e                state_q, state_d;
    logic [CHANNELS_WIDTH-1:0] channel_q, channel_d;
    logic                      edge_q, edge_d;
    logic                      overrun_q, overrun_d;
    logic                      pdm_q, pdm_d;
    logic                      read_q, read_d, integ_q, integ_d;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= S_IDLE;
            channel_q    <= '0;
            edge_q       <= 1'b0;
            overrun_q    <= 1'b0;
            pdm_q        <= 1'b1;
            read_q       <= 1'b0;
            integ_q      <= 1'b0;
            sys_count_q  <= '0;
            comb_count_q <= '0;
        end else begin
            state_q      <= state_d;
            channel_q    <= channel_d;
            edge_q       <= edge_d;
            overrun_q    <= overrun_d;
            pdm_q        <= pdm_d;
            read_q       <= read_d;
            integ_q      <= integ_d;
            sys_count_q  <= sys_count_d;
            comb_count_q <= comb_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        edge_d    = edge_q;
        unique case (state_q)
            S_IDLE: if (read_pt) begin
                state_d = S_READ;
                edge_d  = !hit_p0;
            end
            S_READ: begin
                state_d   = S_COMPUTE;
                channel_d = '0;
            end
            S_COMPUTE: state_d = S_HOLD;
            S_HOLD: begin
                if (channel_q == CHANNELS_WIDTH'(CHANNELS-1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_COMPUTE;
                    channel_d = channel_q + CHANNELS_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A dropped read point outranks a same-cycle clear so it is never lost.
        overrun_d = load_ok ? 1'b0 : overrun_q;
        if (read_pt && (state_q != S_IDLE))
            overrun_d = 1'b1;
    end

    // Outputs are decoded from next state/count so the flops line up with
    // the state and counter registers.
    always_comb begin
        read_d  = (state_d == S_READ);
        integ_d = (state_d == S_COMPUTE) || (state_d == S_HOLD);
        pdm_d   = ({1'b0, sys_count_d} < half);
    end

    assign pdm_clk           = pdm_q;
    assign read_enable       = read_q;
    assign edge_sel          = edge_q;
    assign integrator_enable = integ_q;
    assign channel           = channel_q;
    assign comb_enable       = comb_en;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_cic_timing_ctrl.sv
// Scoreboard bench for cic_timing_ctrl. Expected strobe times are absolute
// cycle numbers written from hand-derived offsets relative to the cycle in
// which sys_count is 0 after a reset release or a config boundary.
module tb_cic_timing_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] cfg_div = 8'd49, cfg_read_time = 8'd28;
    logic [15:0] cfg_sample_rate = 16'd186;
    logic       cfg_dual_edge = 1'b0, cfg_load = 1'b0;
    logic       cfg_ack, cfg_reject, pdm_clk, read_enable, edge_sel;
    logic       integrator_enable, comb_enable, overrun;
    logic [2:0] channel;

    cic_timing_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cfg_div(cfg_div), .cfg_read_time(cfg_read_time),
        .cfg_sample_rate(cfg_sample_rate), .cfg_dual_edge(cfg_dual_edge),
        .cfg_load(cfg_load), .cfg_ack(cfg_ack), .cfg_reject(cfg_reject),
        .pdm_clk(pdm_clk), .read_enable(read_enable), .edge_sel(edge_sel),
        .integrator_enable(integrator_enable), .channel(channel),
        .comb_enable(comb_enable), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; int v; } ev_t;
    ev_t rd_q[$], ch_q[$], cb_q[$], ack_q[$], rej_q[$];

    int  checks = 0, errors = 0;
    bit  mon_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read strobe at t, then 'slots' integrator cycles: channel j/2.
    task automatic exp_sweep(input int t, input int e, input int slots);
        rd_q.push_back('{t, e});
        for (int j = 0; j < slots; j++) ch_q.push_back('{t + 1 + j, j / 2});
    endtask

    task automatic wait_to(input int t);
        if (cyc > t) chk("schedule", cyc, t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic load(input int d, input int rt, input int sr, input bit du);
        cfg_div         = 8'(d);
        cfg_read_time   = 8'(rt);
        cfg_sample_rate = 16'(sr);
        cfg_dual_edge   = du;
        cfg_load        = 1'b1;
        @(negedge clk);
        cfg_load        = 1'b0;
    endtask

    // Monitor: every strobe seen must match the oldest expectation of its kind.
    always @(negedge clk) begin : mon
        ev_t e;
        if (mon_on) begin
            if (read_enable) begin
                if (rd_q.size() == 0) chk("read_enable_unexpected", cyc, -1);
                else begin
                    e = rd_q.pop_front();
                    chk("read_enable_time", cyc, e.t);
                    chk("edge_sel", int'(edge_sel), e.v);
                end
            end
            if (integrator_enable) begin
                if (ch_q.size() == 0) chk("integ_unexpected", cyc, -1);
                else begin
                    e = ch_q.pop_front();
                    chk("integ_time", cyc, e.t);
                    chk("channel", int'(channel), e.v);
                end
            end
            if (comb_enable) begin
                if (cb_q.size() == 0) chk("comb_unexpected", cyc, -1);
                else begin e = cb_q.pop_front(); chk("comb_time", cyc, e.t); end
            end
            if (cfg_ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", cyc, -1);
                else begin e = ack_q.pop_front(); chk("ack_time", cyc, e.t); end
            end
            if (cfg_reject) begin
                if (rej_q.size() == 0) chk("reject_unexpected", cyc, -1);
                else begin e = rej_q.pop_front(); chk("reject_time", cyc, e.t); end
            end
        end
    end

    initial begin
        int b, b2, b3, b4, b5;
        repeat (3) @(negedge clk);
        chk("rst_pdm_clk", int'(pdm_clk), 1);
        chk("rst_read_enable", int'(read_enable), 0);
        chk("rst_integ", int'(integrator_enable), 0);
        chk("rst_channel", int'(channel), 0);
        chk("rst_comb", int'(comb_enable), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_ack", int'(cfg_ack), 0);
        chk("rst_reject", int'(cfg_reject), 0);
        chk("rst_edge_sel", int'(edge_sel), 0);

        // Defaults: div 49, read 28, ratio 187; illegal loads rejected.
        b = cyc;
        for (int n = 0; n < 187; n++) exp_sweep(b + 50*n + 29, 0, 16);
        cb_q.push_back('{b + 9349, 0});
        rej_q.push_back('{b + 201, 0});
        rej_q.push_back('{b + 301, 0});
        rej_q.push_back('{b + 501, 0});
        ack_q.push_back('{b + 9350, 0});
        resetn = 1'b0;
        mon_on = 1'b1;
        chk("pdm_b0", int'(pdm_clk), 1);
        wait_to(b + 24); chk("pdm_b24", int'(pdm_clk), 1);
        wait_to(b + 25); chk("pdm_b25", int'(pdm_clk), 0);
        wait_to(b + 49); chk("pdm_b49", int'(pdm_clk), 0);
        wait_to(b + 50); chk("pdm_b50", int'(pdm_clk), 1);
        wait_to(b + 200); load(2, 1, 186, 1'b0);
        wait_to(b + 300); load(49, 60, 186, 1'b0);

        // Dual-edge, ratio 4; applied at the first default boundary.
        wait_to(b + 400); load(49, 28, 3, 1'b1);
        b2 = b + 9350;
        for (int n = 0; n < 28; n++) begin
            exp_sweep(b2 + 50*n + 4, 1, 16);
            exp_sweep(b2 + 50*n + 29, 0, 16);
        end
        cb_q.push_back('{b2 + 199, 0});
        cb_q.push_back('{b2 + 599, 0});
        cb_q.push_back('{b2 + 999, 0});
        cb_q.push_back('{b2 + 1399, 0});
        ack_q.push_back('{b2 + 200, 0});
        wait_to(b + 500); load(2, 28, 3, 1'b1);

        // Back-to-back loads: only the ratio-8 one survives, one ack.
        wait_to(b2 + 20); load(49, 28, 3, 1'b1);
        wait_to(b2 + 60); load(49, 28, 7, 1'b1);

        // Overrun config: period 20, P0 at 5, P1 at 15 lands mid-sweep.
        wait_to(b2 + 1020); load(19, 5, 7, 1'b1);
        b3 = b2 + 1400;
        for (int n = 0; n < 24; n++) exp_sweep(b3 + 20*n + 6, 0, 16);
        cb_q.push_back('{b3 + 159, 0});
        cb_q.push_back('{b3 + 319, 0});
        cb_q.push_back('{b3 + 479, 0});
        ack_q.push_back('{b3, 0});
        wait_to(b3 - 1);  chk("ovr_before", int'(overrun), 0);
        wait_to(b3 + 9);  chk("pdm_ovr9", int'(pdm_clk), 1);
        wait_to(b3 + 10); chk("pdm_ovr10", int'(pdm_clk), 0);
        wait_to(b3 + 15); chk("ovr_b15", int'(overrun), 0);
        wait_to(b3 + 16); chk("ovr_b16", int'(overrun), 1);
        wait_to(b3 + 100); chk("ovr_sticky", int'(overrun), 1);

        // Legal load clears overrun; it sets again at the next dropped P1.
        wait_to(b3 + 330); load(49, 28, 3, 1'b0);
        b4 = b3 + 480;
        ack_q.push_back('{b4, 0});
        exp_sweep(b4 + 29, 0, 9);
        wait_to(b3 + 331); chk("ovr_cleared", int'(overrun), 0);
        wait_to(b3 + 336); chk("ovr_reset_again", int'(overrun), 1);

        // Reset while channel 4 is in COMPUTE.
        wait_to(b4 + 38);
        chk("mid_channel", int'(channel), 4);
        chk("mid_overrun", int'(overrun), 1);
        resetn = 1'b1;
        wait_to(b4 + 39);
        chk("rs_integ", int'(integrator_enable), 0);
        chk("rs_channel", int'(channel), 0);
        chk("rs_pdm_clk", int'(pdm_clk), 1);
        chk("rs_overrun", int'(overrun), 0);
        chk("rs_read", int'(read_enable), 0);
        wait_to(b4 + 40);
        resetn = 1'b0;

        // Default timing, including the 9350-cycle ratio, resumes.
        b5 = b4 + 40;
        for (int n = 0; n < 187; n++) exp_sweep(b5 + 50*n + 29, 0, 16);
        cb_q.push_back('{b5 + 9349, 0});
        wait_to(b5 + 25); chk("pdm_r25", int'(pdm_clk), 0);
        wait_to(b5 + 50); chk("pdm_r50", int'(pdm_clk), 1);
        wait_to(b5 + 9360);

        chk("rd_left", rd_q.size(), 0);
        chk("ch_left", ch_q.size(), 0);
        chk("comb_left", cb_q.size(), 0);
        chk("ack_left", ack_q.size(), 0);
        chk("rej_left", rej_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
